// File: rtl/crc_frame_ctrl_if.sv
// Word-in / CRC-out handshake bundle between crc_frame_ctrl and its client.
// The client supplies words and consumes collected CRCs; the controller is the slave.
interface crc_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CRC_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [CRC_WIDTH-1:0]  out_crc;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_crc, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_crc, out_valid
  );
endinterface

// File: rtl/crc_frame_ctrl.sv
// Sequencer for the bit-serial CRC engine: latches a word, pulses the engine reset,
// shifts the word out LSB-first and gathers the serial CRC into a parallel result.
module crc_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CRC_WIDTH  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic            CLK,
  input  logic            RST,
  crc_frame_ctrl_if.slave bus,
  output logic            eng_rst_n,
  output logic            eng_data,
  output logic            eng_active,
  input  logic            eng_valid,
  input  logic            eng_crc,
  output logic            err_timeout,
  output logic            err_drop,
  output logic            busy
);
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int COL_W  = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(CRC_WIDTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ENG_RST    = 3'd1,
    S_SHIFT      = 3'd2,
    S_WAIT_VALID = 3'd3,
    S_COLLECT    = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0]     wait_inc;
  logic [COL_W-1:0]      col_cnt_q, col_cnt_d;
  logic [CRC_WIDTH-1:0]  out_crc_q, out_crc_d;
  logic                  in_ready_q, in_ready_d;
  logic                  eng_rst_n_q, eng_rst_n_d;
  logic                  eng_data_q, eng_data_d;
  logic                  eng_active_q, eng_active_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_timeout_q, err_timeout_d;
  logic                  err_drop_q, err_drop_d;
  logic                  busy_q, busy_d;

  assign wait_inc = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

  // word_q doubles as the shift register: bit 0 is always the next bit to send
  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    bit_cnt_d     = bit_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    col_cnt_d     = col_cnt_q;
    out_crc_d     = out_crc_q;
    eng_data_d    = 1'b0;
    err_timeout_d = 1'b0;
    err_drop_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          word_d  = bus.in_data;
          state_d = S_ENG_RST;
        end
      end

      S_ENG_RST: begin
        bit_cnt_d  = '0;
        eng_data_d = word_q[0];
        word_d     = word_q >> 1;
        state_d    = S_SHIFT;
      end

      S_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT_VALID;
        end else begin
          bit_cnt_d  = bit_cnt_q + 1'b1;
          eng_data_d = word_q[0];
          word_d     = word_q >> 1;
        end
      end

      S_WAIT_VALID: begin
        wait_cnt_d = wait_inc;
        if (eng_valid) begin
          out_crc_d[0] = eng_crc;
          col_cnt_d    = COL_W'(1);
          state_d      = (CRC_WIDTH == 1) ? S_DONE : S_COLLECT;
        end else if (wait_inc == WAIT_MAX) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

      // A dropped valid abandons the frame; the half-filled out_crc is left as is
      S_COLLECT: begin
        if (!eng_valid) begin
          err_drop_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          out_crc_d[col_cnt_q] = eng_crc;
          if (col_cnt_q == COL_LAST) begin
            state_d = S_DONE;
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d   = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    eng_rst_n_d  = (state_d != S_ENG_RST);
    eng_active_d = (state_d == S_SHIFT);
    out_valid_d  = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      word_q        <= '0;
      bit_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      col_cnt_q     <= '0;
      out_crc_q     <= '0;
      in_ready_q    <= 1'b1;
      eng_rst_n_q   <= 1'b1;
      eng_data_q    <= 1'b0;
      eng_active_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_drop_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      bit_cnt_q     <= bit_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      col_cnt_q     <= col_cnt_d;
      out_crc_q     <= out_crc_d;
      in_ready_q    <= in_ready_d;
      eng_rst_n_q   <= eng_rst_n_d;
      eng_data_q    <= eng_data_d;
      eng_active_q  <= eng_active_d;
      out_valid_q   <= out_valid_d;
      err_timeout_q <= err_timeout_d;
      err_drop_q    <= err_drop_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_crc   = out_crc_q;
  assign bus.out_valid = out_valid_q;
  assign eng_rst_n     = eng_rst_n_q;
  assign eng_data      = eng_data_q;
  assign eng_active    = eng_active_q;
  assign err_timeout   = err_timeout_q;
  assign err_drop      = err_drop_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: directed framing scenarios plus randomized back-to-back
// words, with a serial engine model and a scoreboard fed at accept time.
module tb_crc_frame_ctrl;
  logic clk, rst;
  logic eng_rst_n, eng_data, eng_active, eng_valid, eng_crc;
  logic err_timeout, err_drop, busy;

  crc_frame_ctrl_if #(.DATA_WIDTH(8), .CRC_WIDTH(8)) bus ();

  crc_frame_ctrl #(.DATA_WIDTH(8), .CRC_WIDTH(8), .TIMEOUT(16)) dut (
    .CLK        (clk),
    .RST        (rst),
    .bus        (bus),
    .eng_rst_n  (eng_rst_n),
    .eng_data   (eng_data),
    .eng_active (eng_active),
    .eng_valid  (eng_valid),
    .eng_crc    (eng_crc),
    .err_timeout(err_timeout),
    .err_drop   (err_drop),
    .busy       (busy)
  );

  typedef struct {
    int         kind;   // 0 = CRC result, 1 = timeout pulse, 2 = drop pulse
    logic [7:0] crc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_pushed = 0;
  int   n_results = 0;

  logic       ready_val = 1'b1;
  logic       ready_rand = 1'b0;
  logic       eng_fixed_en = 1'b1;
  logic [7:0] eng_fixed = 8'h3C;
  int         eng_delay = 0;
  logic       rand_delay = 1'b0;
  int         eng_nvalid = 8;

  logic [7:0] b2b_words [10] = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01,
                                 8'h80, 8'h3C, 8'hC3, 8'h7E, 8'h96};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference CRC-8 (poly x^8+x^2+x+1, zero init), bits fed LSB of the word first
  function automatic logic [7:0] crc8(input logic [7:0] w);
    int c = 0;
    for (int i = 0; i < 8; i++) begin
      int fb = ((c >> 7) & 1) ^ int'(w[i]);
      c = (c << 1) & 255;
      if (fb != 0) c = c ^ 7;
    end
    return 8'(c);
  endfunction

  function automatic logic [15:0] out_vec();
    return {bus.in_ready, eng_rst_n, eng_data, eng_active, bus.out_valid,
            err_timeout, err_drop, busy, bus.out_crc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [7:0] crc);
    exp_t e;
    e.kind = kind;
    e.crc  = crc;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("in_ready_wait", 32'(bus.in_ready), 1);
  endtask

  // Returns at cycle 1 (the cycle after the accept edge); kind 3 pushes nothing
  task automatic send(input logic [7:0] w, input int kind, input logic [7:0] crc,
                      input logic keep_valid);
    wait_ready();
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    if (kind < 3) push(kind, crc);
    step();
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    chk(name, 32'(exp_q.size()), 0);
  endtask

  // Client side of the output handshake
  initial begin : consumer
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_val;
    end
  end

  // Engine model: gathers the shifted word, then streams its CRC LSB-first
  initial begin : engine
    logic [7:0] bits, val;
    int nb, d;
    eng_valid = 1'b0;
    eng_crc   = 1'b0;
    forever begin
      step();
      if (eng_active) begin
        bits = '0;
        nb   = 0;
        while (eng_active && nb < 64) begin
          if (nb < 8) bits[nb] = eng_data;
          nb++;
          step();
        end
        if (nb == 8 && !rst) begin
          val = eng_fixed_en ? eng_fixed : crc8(bits);
          d   = rand_delay ? int'($urandom_range(0, 6)) : eng_delay;
          repeat (d) step();
          for (int i = 0; i < eng_nvalid; i++) begin
            eng_valid = 1'b1;
            eng_crc   = val[i];
            step();
          end
          eng_valid = 1'b0;
          eng_crc   = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int   act_kind;
    forever begin
      @(negedge clk);
      if (!rst && ((bus.out_valid && bus.out_ready) || err_timeout || err_drop)) begin
        act_kind = (bus.out_valid && bus.out_ready) ? 0 : (err_timeout ? 1 : 2);
        chk("sb_event_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_results++;
          chk("sb_kind", 32'(act_kind), 32'(e.kind));
          if (act_kind == 0 && e.kind == 0) chk("sb_out_crc", 32'(bus.out_crc), 32'(e.crc));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] bits, w;
    logic       ok, seen;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) step();
    chk("reset_outputs", 32'(out_vec()), 32'hC000);
    rst = 1'b0;
    step();
    chk("idle_in_ready", 32'(bus.in_ready), 1);

    // Nominal frame
    send(8'hA5, 0, 8'h3C, 1'b0);
    chk("nom_eng_rst_n_c1", 32'(eng_rst_n), 0);
    chk("nom_in_ready_c1", 32'(bus.in_ready), 0);
    chk("nom_busy_c1", 32'(busy), 1);
    ok   = 1'b1;
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      bits[i] = eng_data;
      ok &= eng_active & eng_rst_n;
    end
    chk("nom_eng_data_bits", 32'(bits), 32'hA5);
    chk("nom_eng_active_c2_9", 32'(ok), 1);
    step();
    chk("nom_active_off_c10", 32'(eng_active), 0);
    repeat (7) step();
    chk("nom_out_valid_c17", 32'(bus.out_valid), 0);
    step();
    chk("nom_out_valid_c18", 32'(bus.out_valid), 1);
    chk("nom_out_crc_c18", 32'(bus.out_crc), 32'h3C);
    step();
    chk("nom_in_ready_c19", 32'(bus.in_ready), 1);
    chk("nom_out_valid_c19", 32'(bus.out_valid), 0);

    // Backpressure: out_ready low for cycles 18..22
    send(8'hA5, 0, 8'h3C, 1'b0);
    repeat (16) step();
    ready_val = 1'b0;
    step();
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ok &= bus.out_valid && (bus.out_crc == 8'h3C) && !bus.in_ready;
      step();
    end
    chk("bp_hold_c18_22", 32'(ok), 1);
    chk("bp_valid_c23", 32'(bus.out_valid), 1);
    ready_val = 1'b1;
    step();
    chk("bp_in_ready_c24", 32'(bus.in_ready), 1);
    chk("bp_out_valid_c24", 32'(bus.out_valid), 0);

    // Timeout: engine never answers
    eng_nvalid = 0;
    w = 8'($urandom);
    send(w, 1, 8'h00, 1'b0);
    ok   = 1'b1;
    seen = 1'b0;
    for (int c = 2; c <= 25; c++) begin
      step();
      ok &= !bus.out_valid;
      seen |= err_timeout;
    end
    chk("to_no_early_pulse", 32'(seen), 0);
    step();
    chk("to_pulse_c26", 32'(err_timeout), 1);
    ok &= !bus.out_valid;
    step();
    chk("to_pulse_end_c27", 32'(err_timeout), 0);
    chk("to_in_ready_c27", 32'(bus.in_ready), 1);
    chk("to_no_out_valid", 32'(ok), 1);

    // Valid drop after three CRC bits
    eng_nvalid = 3;
    w = 8'($urandom);
    send(w, 2, 8'h00, 1'b0);
    seen = 1'b0;
    for (int c = 2; c <= 13; c++) begin
      step();
      seen |= err_drop | bus.out_valid;
    end
    chk("drop_quiet_c2_13", 32'(seen), 0);
    step();
    chk("drop_pulse_c14", 32'(err_drop), 1);
    chk("drop_in_ready_c14", 32'(bus.in_ready), 1);
    step();
    chk("drop_pulse_end_c15", 32'(err_drop), 0);
    chk("drop_no_out_valid", 32'(bus.out_valid), 0);

    // Reset during SHIFT, then a clean 8'h00 frame
    eng_nvalid   = 8;
    eng_fixed_en = 1'b0;
    w = 8'($urandom);
    send(w, 3, 8'h00, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("rst_mid_outputs", 32'(out_vec()), 32'hC000);
    rst = 1'b0;
    step();
    send(8'h00, 0, crc8(8'h00), 1'b0);
    wait_drain("rst_followup_drain");

    // Back-to-back with in_valid held high, random engine delay and backpressure
    ready_rand = 1'b1;
    rand_delay = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w = (i < 10) ? b2b_words[i] : 8'($urandom);
      send(w, 0, crc8(w), 1'b1);
    end
    bus.in_valid = 1'b0;
    wait_drain("b2b_drain");
    ready_rand = 1'b0;
    repeat (5) step();
    chk("result_count", 32'(n_results), 32'(n_pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/crc_frame_ctrl.md
Name: crc_frame_ctrl

Overview:
Sequencer for the team's bit-serial CRC engine (Data/Active/CLK/RST/valid/CRC interface). It accepts one parallel data word over a valid/ready handshake and pulses the engine reset. It then shifts the word into the engine LSB-first and collects the engine's serial CRC output into a parallel result. The result is presented over a valid/ready handshake, with a timeout if the engine never asserts valid.

Parameters:
DATA_WIDTH, 8, bits per input word shifted into the engine
CRC_WIDTH, 8, bits of CRC collected from the engine
TIMEOUT, 16, max cycles in WAIT_VALID before abort (>=1)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  reset, synchronous, active-high
in_data  in  DATA_WIDTH  word to be CRC'd
in_valid  in  1  in_data valid
in_ready  out  1  controller can accept a word
eng_rst_n  out  1  to engine RST (active-low)
eng_data  out  1  to engine Data
eng_active  out  1  to engine Active
eng_valid  in  1  from engine valid
eng_crc  in  1  from engine CRC serial bit
out_crc  out  CRC_WIDTH  collected CRC, bit i = i-th serial bit received
out_valid  out  1  out_crc valid
out_ready  in  1  consumer accepts out_crc
err_timeout  out  1  one-cycle pulse on WAIT_VALID timeout
err_drop  out  1  one-cycle pulse if eng_valid falls during COLLECT
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (RST=1 at a rising edge, any state): state=IDLE, counters=0; in_ready=1, eng_rst_n=1, eng_data=0, eng_active=0, out_crc=0, out_valid=0, err_timeout=0, err_drop=0, busy=0. A reset mid-frame discards the frame; no out_valid and no error pulse are produced.
- All outputs are registered (Moore). Cycle numbers below are relative to the accept edge (cycle 0).
- IDLE: in_ready=1. On in_valid & in_ready, latch in_data and go to ENG_RST. in_ready drops to 0 the next cycle.
- ENG_RST (1 cycle, cycle 1): eng_rst_n=0, eng_active=0. Go to SHIFT.
- SHIFT (cycles 2..DATA_WIDTH+1): eng_active=1, eng_data=word[bit_cnt], bit_cnt 0..DATA_WIDTH-1, LSB first. After the last bit, go to WAIT_VALID.
- WAIT_VALID: eng_active=0, eng_data=0, the wait counter increments each cycle.
  - eng_valid sampled 1: capture eng_crc into out_crc bit 0 on the same edge and go to COLLECT with col_cnt=1.
  - Counter reaches TIMEOUT with no eng_valid: pulse err_timeout for 1 cycle and return to IDLE. out_crc is unchanged.
- COLLECT: each edge captures eng_crc into out_crc[col_cnt] and increments col_cnt.
  - After bit CRC_WIDTH-1, go to DONE.
  - If eng_valid is sampled 0 before all bits are captured, pulse err_drop and return to IDLE. out_valid is not asserted; the partially written out_crc is don't-care.
- DONE: out_valid=1, out_crc held stable. On out_valid & out_ready, out_valid drops and the state returns to IDLE.
  - in_ready stays 0 until IDLE, so there is no overlap between frames.
  - The earliest new accept is the cycle after the handshake.
- Minimum latency, with the engine asserting valid on the first WAIT_VALID cycle and out_ready=1:
  - accept at cycle 0;
  - bit 0 captured at cycle DATA_WIDTH+2 (10 for defaults);
  - out_valid first high at cycle DATA_WIDTH+CRC_WIDTH+2 (18);
  - back in IDLE with in_ready=1 at cycle 19.
- in_valid while busy is ignored; no word is latched.
- bit_cnt and col_cnt are sized to clog2 of their width and must not wrap inside a frame. The wait counter saturates at TIMEOUT.

Test Plan:
- Nominal: in_data=8'hA5. Engine model asserts valid at cycle 10 and serialises 8'h3C LSB-first. Required: eng_rst_n=0 at cycle 1 only; eng_data=1,0,1,0,0,1,0,1 on cycles 2..9 with eng_active=1; out_crc=8'h3C with out_valid high at cycle 18.
- Backpressure: as nominal but out_ready=0 for 5 cycles after out_valid rises. Required: out_valid and out_crc=8'h3C stable throughout, in_ready=0, and IDLE reached the cycle after out_ready=1.
- Timeout: engine never asserts valid. Required: err_timeout high for exactly 1 cycle, 16 cycles after WAIT_VALID entry; out_valid never rises; in_ready=1 the next cycle.
- Valid drop: eng_valid high for 3 cycles, then low. Required: err_drop single pulse, out_valid stays 0, return to IDLE.
- Reset mid-SHIFT: RST=1 at cycle 5. Required: the next cycle shows all outputs at reset values, and a subsequent 8'h00 frame completes normally.
- Back-to-back: 10 words read from a $readmemh file (same vectors as the engine bench). Each out_crc must match the expected file, and in_valid held high during busy must never cause a double accept.
